imem_loader: RTL

- Write-side counterpart of the CPU's instruction memory: fills a writable instruction RAM from a byte stream (e.g. UART RX) before the single-cycle CPU runs.
- Parses a length header, assembles big-endian 32-bit instruction words and issues one word write per instruction at consecutive word addresses from 0.
- Holds the CPU in reset/stall while loading.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Purpose: shared state encoding and sizing constants for the instruction-memory loader.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
//
// The byte-address/word-index shift also lives here because the instruction
// memory read port decodes the same byte address bits [ADDR_W+1:2].
package imem_loader_pkg;

    // Length header is a fixed two-byte big-endian field.
    localparam int LEN_BYTES      = 2;
    // Instructions are 32-bit words streamed MSB first.
    localparam int BYTES_PER_WORD = 4;
    // Byte address = word index << WORD_SHIFT.
    localparam int WORD_SHIFT     = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    // Word index to word-aligned byte address.
    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return word_idx << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Purpose: assembles big-endian 32-bit words from a byte stream (shift register + byte counter).
// Latency: combinational completion; word/word_ready are valid in the same cycle as the 4th byte.
// Backpressure: none of its own; the parent only asserts byte_take on accepted bytes.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear        - restart the byte count (parent drives it whenever it is not collecting data)
//   byte_take    - a data byte is transferred this cycle
//   byte_data    - the byte being transferred
//   word_ready   - this byte completes a word
//   word         - assembled word; first byte received sits in bits [31:24]
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_take,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // The completing byte is not yet in the shift register, so it is spliced
    // in as the low byte here; this lets the parent register the word on the
    // same edge that accepts the last byte.
    assign word       = {shift_q, byte_data};
    assign word_ready = byte_take && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
        end else if (byte_take) begin
            shift_q <= {shift_q[15:0], byte_data};
            // Wraps back to zero after the 4th byte, ready for the next word.
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Purpose: fills the instruction RAM from a byte stream (length header + big-endian words), holding the CPU meanwhile.
// Latency: a RAM write issues the cycle after a word's 4th byte; done pulses the cycle after the final write (or after the header for len==0).
// Backpressure: byte_ready is low for one bubble cycle per word (WRITE) and outside an active load; bytes move only on byte_valid && byte_ready.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - one-cycle pulse, begin a load (honoured in IDLE and ERR only)
//   byte_valid/byte_data  - incoming stream byte
//   byte_ready            - loader takes the byte this cycle
//   mem_we/mem_addr/mem_wdata - RAM write port; address is a word-aligned byte address, held between writes
//   cpu_hold              - keep the CPU stalled while loading or after an error
//   done                  - one-cycle pulse on successful completion
//   error                 - sticky; set on oversize length (or checksum mismatch), cleared by start
//
// Build option IMEM_LOADER_CHECKSUM_EN: after the last word (or straight after
// the header when len==0) one trailer byte is accepted and must equal the XOR
// of every header and data byte, otherwise the load ends in ERR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t                  state;
    logic [7:0]              len_hi_q;
    logic [LEN_W-1:0]        len_q;
    logic [ADDR_W-1:0]       word_idx;

    logic                    take;
    logic                    asm_take;
    logic                    asm_clear;
    logic                    word_ready;
    logic [31:0]             word;

    logic [LEN_BYTES*8-1:0]  hdr_len;
    logic [LEN_W-1:0]        len_next;
    logic                    len_oversize;
    logic                    last_word;

    assign take      = byte_valid && byte_ready;
    assign asm_take  = take && (state == DATA);
    assign asm_clear = (state != DATA);

    // Full length as seen on the edge that accepts the low header byte.
    assign hdr_len      = {len_hi_q, byte_data};
    assign len_next     = LEN_W'(hdr_len);
    // len == 2**ADDR_W exactly fills the RAM and is legal.
    assign len_oversize = 32'(len_next) > (32'd1 << ADDR_W);
    assign last_word    = (32'(word_idx) + 32'd1) == 32'(len_q);

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_take  (asm_take),
        .byte_data  (byte_data),
        .word_ready (word_ready),
        .word       (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running XOR of header and data bytes; the trailer byte (taken in CHK)
    // is compared against it, never folded in.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start && (state == IDLE || state == ERR)) begin
            csum_q <= '0;
        end else if (take && (state != CHK)) begin
            csum_q <= csum_q ^ byte_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_idx   <= '0;
        end else begin
            // Single-cycle strobes.
            mem_we <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN_HI;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        error      <= 1'b0;
                    end
                end

                LEN_HI: begin
                    if (take) begin
                        len_hi_q <= byte_data;
                        state    <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (take) begin
                        len_q    <= len_next;
                        word_idx <= '0;
                        if (len_next == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            // Header-only stream still carries a trailer.
                            state <= CHK;
`else
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
`endif
                        end else if (len_oversize) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    // word_ready implies a byte was taken in DATA this cycle.
                    if (word_ready) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= word_to_byte_addr(32'(word_idx));
                        mem_wdata  <= word;
                    end
                end

                WRITE: begin
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= CHK;
                        byte_ready <= 1'b1;
`else
                        state      <= DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
`endif
                    end else begin
                        word_idx   <= word_idx + ADDR_W'(1);
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum_q) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                end

                ERR: begin
                    // cpu_hold and error stay asserted until a new load starts.
                    if (start) begin
                        state      <= LEN_HI;
                        byte_ready <= 1'b1;
                        error      <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule
